bcd_scan_display: RTL and testbench

- N-digit, time-multiplexed 7-segment driver for the reaction-timer display.
- Decodes packed BCD (.gfedcba, active-low) and scans one digit at a time through a prescaler.
- Double-buffers the displayed value, so a new value is swapped in only at a frame boundary and the display never tears.
- Replaces the per-digit decoder plus 2:1 display mux with one scanned output bus.

---
 rtl/bcd_scan_display_if.sv | 23 ++
 rtl/bcd_scan_display.sv | 113 +++++++++++
 tb/tb_bcd_scan_display.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_scan_display_if.sv
// Bus bundle for bcd_scan_display: value/load/blank inputs and the scanned
// segment/anode outputs plus the frame-swap pulse.
interface bcd_scan_display_if #(
  parameter int N_DIGITS = 4
);
  logic [4*N_DIGITS-1:0] bcd_in;
  logic [N_DIGITS-1:0]   dp_in;
  logic                  load;
  logic                  blank;
  logic [7:0]            seg_out;
  logic [N_DIGITS-1:0]   digit_en;
  logic                  frame_swap;

  modport master (
    output bcd_in, dp_in, load, blank,
    input  seg_out, digit_en, frame_swap
  );

  modport slave (
    input  bcd_in, dp_in, load, blank,
    output seg_out, digit_en, frame_swap
  );
endinterface

// File: rtl/bcd_scan_display.sv
// Time-multiplexed N-digit 7-segment driver with a double-buffered value.
// Optional leading-zero blanking: define BCD_SCAN_LZB_EN.
module bcd_scan_display #(
  parameter int N_DIGITS = 4,
  parameter int SCAN_DIV = 50000
) (
  input logic               clk,
  input logic               reset,
  bcd_scan_display_if.slave bus
);
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_DIGITS - 1);

  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic                  started;
  logic [4*N_DIGITS-1:0] disp_bcd, pend_bcd;
  logic [N_DIGITS-1:0]   disp_dp, pend_dp;
  logic                  pend_valid;

  logic                  tick, wrap, swap, started_nx, lz;
  logic [IDX_W-1:0]      idx_nx, idx_show;
  logic [4*N_DIGITS-1:0] disp_bcd_nx;
  logic [N_DIGITS-1:0]   disp_dp_nx;
  logic [3:0]            nib;
  logic                  dp_bit;
  logic [7:0]            seg_nx;
  logic [N_DIGITS-1:0]   en_nx;

  function automatic logic [6:0] decode7(input logic [3:0] v);
    case (v)
      4'd0:    decode7 = 7'h3F;
      4'd1:    decode7 = 7'h06;
      4'd2:    decode7 = 7'h5B;
      4'd3:    decode7 = 7'h4F;
      4'd4:    decode7 = 7'h66;
      4'd5:    decode7 = 7'h6D;
      4'd6:    decode7 = 7'h7D;
      4'd7:    decode7 = 7'h07;
      4'd8:    decode7 = 7'h7F;
      4'd9:    decode7 = 7'h67;
      default: decode7 = 7'h71;
    endcase
  endfunction

  // NOTE: every always_comb output gets a value on every path, so no latches.
  always_comb begin
    tick = (cnt == CNT_MAX);
    // The first tick after reset enters slot 0 rather than advancing past it.
    if (!started || idx == IDX_MAX) idx_nx = '0;
    else                            idx_nx = idx + 1'b1;
    idx_show    = tick ? idx_nx : idx;
    wrap        = tick && (idx_nx == '0);
    swap        = wrap && pend_valid;
    disp_bcd_nx = swap ? pend_bcd : disp_bcd;
    disp_dp_nx  = swap ? pend_dp  : disp_dp;
    nib         = disp_bcd_nx[4*int'(idx_show) +: 4];
    dp_bit      = disp_dp_nx[idx_show];
`ifdef BCD_SCAN_LZB_EN
    lz = (idx_show != '0)
         && ((disp_bcd_nx >> (4*int'(idx_show))) == '0)
         && ((disp_dp_nx >> idx_show) == '0);
`else
    lz = 1'b0;
`endif
    started_nx = started | tick;
    // Outputs are recomputed every edge, but index and display only move on a
    // tick, so they still change only at slot boundaries (or on blank).
    if (!started_nx || bus.blank) begin
      seg_nx = 8'hFF;
      en_nx  = '1;
    end else begin
      seg_nx = lz ? 8'hFF : ~{dp_bit, decode7(nib)};
      en_nx  = ~(N_DIGITS'(1) << idx_show);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt            <= '0;
      idx            <= '0;
      started        <= 1'b0;
      disp_bcd       <= '0;
      disp_dp        <= '0;
      pend_bcd       <= '0;
      pend_dp        <= '0;
      pend_valid     <= 1'b0;
      bus.seg_out    <= 8'hFF;
      bus.digit_en   <= '1;
      bus.frame_swap <= 1'b0;
    end else begin
      cnt      <= tick ? '0 : cnt + 1'b1;
      idx      <= idx_show;
      started  <= started_nx;
      disp_bcd <= disp_bcd_nx;
      disp_dp  <= disp_dp_nx;
      // A load on the swap edge refills pending after the old value moved out.
      if (bus.load) begin
        pend_bcd   <= bus.bcd_in;
        pend_dp    <= bus.dp_in;
        pend_valid <= 1'b1;
      end else if (swap) begin
        pend_valid <= 1'b0;
      end
      bus.seg_out    <= seg_nx;
      bus.digit_en   <= en_nx;
      bus.frame_swap <= swap;
    end
  end
endmodule

// File: tb/tb_bcd_scan_display.sv
// Self-checking bench for bcd_scan_display (N_DIGITS=4, SCAN_DIV=4) against a
// cycle-count based reference model.
module tb_bcd_scan_display;
  localparam int N  = 4;
  localparam int SD = 4;
  localparam int FRAME = N * SD;

  logic clk = 1'b0;
  logic reset = 1'b1;

  bcd_scan_display_if #(.N_DIGITS(N)) ifc ();
  bcd_scan_display #(.N_DIGITS(N), .SCAN_DIV(SD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: everything derives from k, the number of edges since reset release.
  int          k;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_ddp, m_pdp;
  bit          m_pv;
  logic [12:0] exp_out;  // {frame_swap, digit_en, seg_out}

  logic [6:0] lut [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h67};

  function automatic logic [7:0] ref_seg(logic [15:0] v, logic [3:0] dp, int i);
    int nibv;
    logic [6:0] s;
    nibv = int'((v >> (4*i)) & 16'hF);
    s = (nibv > 9) ? 7'h71 : lut[nibv];
`ifdef BCD_SCAN_LZB_EN
    if (i > 0 && (v >> (4*i)) == 16'h0 && (dp >> i) == 4'h0) return 8'hFF;
`endif
    return ~{dp[i], s};
  endfunction

  function automatic logic [12:0] act();
    return {ifc.frame_swap, ifc.digit_en, ifc.seg_out};
  endfunction

  task automatic model_reset();
    k = 0; m_disp = '0; m_pend = '0; m_ddp = '0; m_pdp = '0; m_pv = 0;
    exp_out = {1'b0, 4'hF, 8'hFF};
  endtask

  task automatic model_edge(bit ld, logic [15:0] b, logic [3:0] d, bit bl);
    bit sw;
    int i;
    k++;
    sw = (k % SD == 0) && (((k / SD) - 1) % N == 0) && m_pv;
    if (sw) begin m_disp = m_pend; m_ddp = m_pdp; m_pv = 0; end
    if (ld) begin m_pend = b; m_pdp = d; m_pv = 1; end
    if (k < SD || bl) exp_out = {sw, 4'hF, 8'hFF};
    else begin
      i = ((k / SD) - 1) % N;
      exp_out = {sw, ~(4'b0001 << i), ref_seg(m_disp, m_ddp, i)};
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge(ifc.load, ifc.bcd_in, ifc.dp_in, ifc.blank);
    @(negedge clk);
    ifc.load = 1'b0;
  endtask

  task automatic step_cmp(string name);
    cycle();
    total++;
    if (act() !== exp_out)
      $display("FAIL %s k=%0d got %h expected %h", name, k, act(), exp_out);
    else passed++;
  endtask

  // Advance until the next edge is a frame wrap edge.
  task automatic run_to_wrap();
    while (((k + 1) % FRAME) != SD) step_cmp("run_to_wrap");
  endtask

  task automatic wait_swap();
    bit seen = 0;
    for (int c = 0; c < 3 * FRAME && !seen; c++) begin
      step_cmp("wait_swap");
      seen = ifc.frame_swap;
    end
    total++;
    if (!seen) $display("FAIL swap_timeout got no frame_swap expected one");
    else passed++;
  endtask

  task automatic load_val(logic [15:0] b, logic [3:0] d);
    ifc.bcd_in = b; ifc.dp_in = d; ifc.load = 1'b1;
  endtask

  task automatic test_reset();
    ifc.load = 0; ifc.blank = 0; ifc.bcd_in = '0; ifc.dp_in = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0; model_reset();
    repeat (5) step_cmp("pre_reset");
    load_val(16'h9999, 4'hF);
    step_cmp("pre_reset_load");
    #2 reset = 1'b1;
    #1;
    total++;
    if (act() !== {1'b0, 4'hF, 8'hFF}) $display("FAIL reset_async got %h expected %h", act(), {1'b0, 4'hF, 8'hFF});
    else passed++;
    @(negedge clk);
    reset = 1'b0; model_reset();
    for (int c = 1; c <= SD; c++) begin
      step_cmp("post_reset");
      total++;
      if (c < SD && act() !== {1'b0, 4'hF, 8'hFF}) $display("FAIL reset_hold c=%0d got %h expected 0fff", c, act());
      else if (c == SD && act() !== {1'b0, 4'hE, 8'hC0}) $display("FAIL first_tick got %h expected 0ec0", act());
      else passed++;
    end
  endtask

  task automatic test_load_1234();
    logic [3:0] en_t [0:3] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [7:0] sg_t [0:3] = '{8'h99, 8'h30, 8'hA4, 8'hF9};
    load_val(16'h1234, 4'b0010);
    step_cmp("load_1234");
    wait_swap();
    for (int s = 0; s < 2 * N; s++) begin
      if (s > 0) repeat (SD) step_cmp("scan_1234");
      total++;
      if ({ifc.digit_en, ifc.seg_out} !== {en_t[s%N], sg_t[s%N]})
        $display("FAIL slot_1234 s=%0d got %h expected %h", s, {ifc.digit_en, ifc.seg_out}, {en_t[s%N], sg_t[s%N]});
      else passed++;
    end
  endtask

  task automatic test_hex_lzb();
    logic [7:0] hi;
    logic [7:0] sg_t [0:3];
`ifdef BCD_SCAN_LZB_EN
    hi = 8'hFF;
`else
    hi = 8'hC0;
`endif
    sg_t = '{8'h8E, 8'h8E, hi, hi};
    load_val(16'h00AB, 4'b0000);
    step_cmp("load_00ab");
    wait_swap();
    for (int s = 0; s < N; s++) begin
      if (s > 0) repeat (SD) step_cmp("scan_00ab");
      total++;
      if ({ifc.digit_en, ifc.seg_out} !== {~(4'b0001 << s), sg_t[s]})
        $display("FAIL slot_00ab s=%0d got %h expected %h", s, {ifc.digit_en, ifc.seg_out}, {~(4'b0001 << s), sg_t[s]});
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int swaps = 0, bad = 0;
    run_to_wrap();
    step_cmp("b2b_wrap");
    load_val(16'h1111, 4'h0);
    step_cmp("b2b_load1");
    load_val(16'h2222, 4'h0);
    step_cmp("b2b_load2");
    for (int c = 0; c < 2 * FRAME; c++) begin
      step_cmp("b2b_scan");
      if (ifc.frame_swap) swaps++;
      if (swaps > 0 && ifc.seg_out !== 8'hA4) bad++;
    end
    total++;
    if (swaps != 1) $display("FAIL b2b_swaps got %0d expected 1", swaps);
    else passed++;
    total++;
    if (bad != 0) $display("FAIL b2b_value got %0d non-2 slots expected 0", bad);
    else passed++;
  endtask

  task automatic test_swap_edge_load();
    run_to_wrap();
    step_cmp("se_wrap");
    load_val(16'h5555, 4'h0);
    step_cmp("se_load1");
    run_to_wrap();
    load_val(16'h6666, 4'h0);
    step_cmp("se_swap1");
    total++;
    if (act() !== {1'b1, 4'hE, 8'h92}) $display("FAIL swap_edge_first got %h expected 1e92", act());
    else passed++;
    run_to_wrap();
    step_cmp("se_swap2");
    total++;
    if (act() !== {1'b1, 4'hE, 8'h82}) $display("FAIL swap_edge_second got %h expected 1e82", act());
    else passed++;
  endtask

  task automatic test_blank();
    repeat (5) step_cmp("blank_pre");
    ifc.blank = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step_cmp("blank_on");
      total++;
      if ({ifc.digit_en, ifc.seg_out} !== 12'hFFF) $display("FAIL blank_dark c=%0d got %h expected fff", c, {ifc.digit_en, ifc.seg_out});
      else passed++;
    end
    ifc.blank = 1'b0;
    repeat (2 * SD) step_cmp("blank_release");
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(11) == 0) load_val(16'($urandom), 4'($urandom));
      if ($urandom_range(9) == 0) ifc.blank = ~ifc.blank;
      step_cmp("random");
    end
    ifc.blank = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load_1234();
    test_hex_lzb();
    test_back_to_back();
    test_swap_edge_load();
    test_blank();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
